// File: rtl/seq_detector_1011_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detector_1011_if
// Serial data path signals for the 1011 pattern monitor.
// Revision: 1.0
// ---------------------------------------------------------------------------
interface seq_detector_1011_if;
  logic seq_in;
  logic detect_out;

  modport master (output seq_in, input detect_out);
  modport slave  (input seq_in, output detect_out);
endinterface
`default_nettype wire

// File: rtl/seq_detector_1011.sv
`default_nettype none
// ---------------------------------------------------------------------------
// seq_detector_1011
// Moore, non-overlapping detector for the serial bit pattern 1-0-1-1.
// Revision: 1.0
// ---------------------------------------------------------------------------
module seq_detector_1011 (
  input  wire logic           clk,
  input  wire logic           reset,
  seq_detector_1011_if.slave  bus
);

  typedef enum logic [4:0] {
    IDLE  = 5'b00001,
    S1    = 5'b00010,
    S10   = 5'b00100,
    S101  = 5'b01000,
    S1011 = 5'b10000
  } state_t;

  state_t r_state;
  state_t w_state_next;
  logic   r_detect;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= IDLE;
      r_detect <= 1'b0;
    end else begin
      r_state  <= w_state_next;
      r_detect <= (w_state_next == S1011);
    end
  end

  // After a completed match the pattern bits are not reused; any
  // non-one-hot encoding falls back to IDLE via the default arm.
  always_comb begin
    w_state_next = IDLE;
    case (r_state)
      IDLE:    w_state_next = bus.seq_in ? S1    : IDLE;
      S1:      w_state_next = bus.seq_in ? S1    : S10;
      S10:     w_state_next = bus.seq_in ? S101  : IDLE;
      S101:    w_state_next = bus.seq_in ? S1011 : S10;
      S1011:   w_state_next = bus.seq_in ? S1    : IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  assign bus.detect_out = r_detect;

endmodule
`default_nettype wire

// File: tb/tb_seq_detector_1011.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_seq_detector_1011
// Directed and random checks of the 1011 detector against a history model.
// ---------------------------------------------------------------------------
module tb_seq_detector_1011;

  logic clk;
  logic reset;
  int   n_checks;
  int   n_fails;
  bit   hist[$];
  logic exp_detect;

  seq_detector_1011_if bus ();

  seq_detector_1011 dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Bits seen since the last reset or completed match; a match is simply
  // the last four of them reading 1,0,1,1.
  task automatic model(input bit b, input bit r);
    int n;
    if (r) begin
      hist.delete();
      exp_detect = 1'b0;
    end else begin
      hist.push_back(b);
      n = hist.size();
      if (n >= 4 && hist[n-4] == 1'b1 && hist[n-3] == 1'b0 &&
          hist[n-2] == 1'b1 && hist[n-1] == 1'b1) begin
        exp_detect = 1'b1;
        hist.delete();
      end else begin
        exp_detect = 1'b0;
      end
    end
  endtask

  // Called at posedge+1: drive, glitch seq_in between edges, then check.
  task automatic step(input bit b, input bit r, input string tag);
    reset      = r;
    bus.seq_in = b;
    #2 bus.seq_in = ~b;
    #2 bus.seq_in = b;
    @(posedge clk);
    #1;
    model(b, r);
    n_checks++;
    assert (bus.detect_out === exp_detect) else begin
      n_fails++;
      $error("FAIL %s observed=%b expected=%b", tag, bus.detect_out, exp_detect);
    end
  endtask

  task automatic stream(input bit [15:0] bits, input int len, input string tag);
    for (int i = len - 1; i >= 0; i--) step(bits[i], 1'b0, tag);
  endtask

  initial begin
    n_checks   = 0;
    n_fails    = 0;
    exp_detect = 1'b0;
    reset      = 1'b1;
    bus.seq_in = 1'b0;
    @(posedge clk);
    #1;

    step(1'b1, 1'b1, "reset_state");
    stream(16'b1011000, 7, "basic");
    step(1'b0, 1'b1, "rst");
    stream(16'b1011011, 7, "non_overlap");
    step(1'b0, 1'b1, "rst");
    stream(16'b10111011, 8, "back_to_back");
    step(1'b0, 1'b1, "rst");
    stream(16'b101011, 6, "recover_1010");
    step(1'b0, 1'b1, "rst");
    stream(16'b11011, 5, "recover_11");
    step(1'b0, 1'b1, "rst");
    stream(16'b1001011, 7, "recover_100");

    step(1'b0, 1'b1, "rst");
    stream(16'b101, 3, "mid_reset_pre");
    step(1'b1, 1'b1, "mid_reset");
    stream(16'b011, 3, "mid_reset_post");

    step(1'b0, 1'b1, "rst");
    stream(16'b1011, 4, "pulse_then_reset");
    step(1'b1, 1'b1, "reset_drops_detect");

    for (int i = 0; i < 20; i++) step(1'b0, 1'b0, "all_zero");
    for (int i = 0; i < 20; i++) step(1'b1, 1'b0, "all_one");

    for (int i = 0; i < 600; i++) begin
      step(bit'($urandom_range(0, 99) < 60), bit'($urandom_range(0, 49) == 0),
           "random");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
`default_nettype wire
